// File: rtl/mod_n_digit_counter.sv
// mod_n_digit_counter
//   Cascaded-digit modulo counter built from NDIG 4-bit digits. It counts
//   0..Last, wraps to 0, and raises C in the cycle whose edge wraps Q.
//   Each digit is binary (RADIX=16) or BCD (RADIX=10). The counter
//   supports enable, synchronous parallel load and synchronous reset.
//
//   Optional feature macro: CNT_UPDOWN_EN
//     defined   : Up selects the direction (1 = up, 0 = down). Counting
//                 down from 0, or from any value above Last, reloads Last.
//     undefined : up-only counter. Up is accepted but ignored, and no
//                 decrement/borrow logic is built.
//
// Ports
//   Clk   in   1        rising-edge clock
//   MR    in   1        synchronous reset, active-high (highest priority)
//   En    in   1        count enable
//   Ld    in   1        synchronous load of D (wins over En)
//   Up    in   1        count direction (used only with CNT_UPDOWN_EN)
//   D     in   4*NDIG   load value, digit-encoded
//   Last  in   4*NDIG   terminal value, digit-encoded; modulus = Last+1
//   Q     out  4*NDIG   count, digit i = Q[4i+3:4i]
//   C     out  1        carry/borrow, combinational from Q/En/Ld/MR/Last
module mod_n_digit_counter #(
  parameter int unsigned NDIG  = 2,
  parameter int unsigned RADIX = 16
) (
  input  logic              Clk,
  input  logic              MR,
  input  logic              En,
  input  logic              Ld,
  input  logic              Up,
  input  logic [4*NDIG-1:0] D,
  input  logic [4*NDIG-1:0] Last,
  output logic [4*NDIG-1:0] Q,
  output logic              C
);

  localparam int unsigned W    = 4 * NDIG;
  localparam logic [3:0]  DMAX = 4'(RADIX - 1);

  logic [W-1:0] q_q, q_d;
  logic [W-1:0] inc_val;
  logic [W-1:0] step_val;
  logic         inc_cy;
  logic         wrap;

  // Digit-wise increment. A digit at or above RADIX-1 (including illegal
  // BCD values) rolls to 0 and carries into the next digit.
  always_comb begin
    inc_val = q_q;
    inc_cy  = 1'b1;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (inc_cy) begin
        if (q_q[4*i +: 4] >= DMAX) begin
          inc_val[4*i +: 4] = '0;
        end else begin
          inc_val[4*i +: 4] = q_q[4*i +: 4] + 4'd1;
          inc_cy            = 1'b0;
        end
      end
    end
  end

`ifdef CNT_UPDOWN_EN
  logic [W-1:0] dec_val;
  logic         dec_bw;

  // Digit-wise decrement. Only a 0 digit borrows; an illegal digit just
  // drops by one with no borrow.
  always_comb begin
    dec_val = q_q;
    dec_bw  = 1'b1;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (dec_bw) begin
        if (q_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = DMAX;
        end else begin
          dec_val[4*i +: 4] = q_q[4*i +: 4] - 4'd1;
          dec_bw            = 1'b0;
        end
      end
    end
  end

  // Packed digits compare numerically as a plain vector for both radices.
  assign wrap     = Up ? (q_q >= Last) : ((q_q == '0) || (q_q > Last));
  assign step_val = Up ? (wrap ? '0 : inc_val) : (wrap ? Last : dec_val);
`else
  logic unused_up;
  assign unused_up = Up;

  assign wrap     = (q_q >= Last);
  assign step_val = wrap ? '0 : inc_val;
`endif

  always_comb begin
    q_d = q_q;
    if (Ld) begin
      q_d = D;
    end else if (En) begin
      q_d = step_val;
    end
  end

  always_ff @(posedge Clk) begin
    if (MR) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;
  assign C = En & ~MR & ~Ld & wrap;

endmodule

// File: tb/tb_mod_n_digit_counter.sv
module tb_mod_n_digit_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Hex 2-digit instance
  logic       h_mr, h_en, h_ld, h_up, h_c;
  logic [7:0] h_d, h_last, h_q;
  // BCD 3-digit instance
  logic        b3_mr, b3_en, b3_ld, b3_up, b3_c;
  logic [11:0] b3_d, b3_last, b3_q;
  // BCD 2-digit instance
  logic       b2_mr, b2_en, b2_ld, b2_up, b2_c;
  logic [7:0] b2_d, b2_last, b2_q;

  mod_n_digit_counter #(.NDIG(2), .RADIX(16)) u_hex (
    .Clk(clk), .MR(h_mr), .En(h_en), .Ld(h_ld), .Up(h_up),
    .D(h_d), .Last(h_last), .Q(h_q), .C(h_c)
  );

  mod_n_digit_counter #(.NDIG(3), .RADIX(10)) u_bcd3 (
    .Clk(clk), .MR(b3_mr), .En(b3_en), .Ld(b3_ld), .Up(b3_up),
    .D(b3_d), .Last(b3_last), .Q(b3_q), .C(b3_c)
  );

  mod_n_digit_counter #(.NDIG(2), .RADIX(10)) u_bcd2 (
    .Clk(clk), .MR(b2_mr), .En(b2_en), .Ld(b2_ld), .Up(b2_up),
    .D(b2_d), .Last(b2_last), .Q(b2_q), .C(b2_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] to_bcd3(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic test_reset();
    h_mr = 1'b1; b3_mr = 1'b1; b2_mr = 1'b1;
    h_en = 1'b1; b3_en = 1'b1; b2_en = 1'b1;
    tick();
    checks++;
    if (h_q !== 8'h00) begin failures++; $display("FAIL reset_hex_q got=%h want=00", h_q); end
    checks++;
    if (b3_q !== 12'h000) begin failures++; $display("FAIL reset_bcd3_q got=%h want=000", b3_q); end
    checks++;
    if (b2_q !== 8'h00) begin failures++; $display("FAIL reset_bcd2_q got=%h want=00", b2_q); end
    checks++;
    if ({h_c, b3_c, b2_c} !== 3'b000) begin
      failures++; $display("FAIL reset_c got=%b want=000", {h_c, b3_c, b2_c});
    end
    h_mr = 1'b0; b3_mr = 1'b0; b2_mr = 1'b0;
    h_en = 1'b0; b3_en = 1'b0; b2_en = 1'b0;
  endtask

  task automatic test_hex_sequence();
    logic [7:0] exp;
    int         c_cnt;
    exp = 8'h00; c_cnt = 0;
    h_last = 8'h78; h_up = 1'b1; h_en = 1'b1;
    for (int k = 0; k < 121; k++) begin
      #1;
      checks++;
      if (h_c !== (exp == 8'h78)) begin
        failures++; $display("FAIL hex_seq_c q=%h got=%b want=%b", exp, h_c, exp == 8'h78);
      end
      if (h_c) c_cnt++;
      tick();
      exp = (exp == 8'h78) ? 8'h00 : exp + 8'h01;
      checks++;
      if (h_q !== exp) begin failures++; $display("FAIL hex_seq_q got=%h want=%h", h_q, exp); end
    end
    checks++;
    if (c_cnt !== 1) begin failures++; $display("FAIL hex_seq_c_count got=%0d want=1", c_cnt); end
    h_en = 1'b0;
  endtask

  task automatic test_bcd_sequence();
    int n;
    int c_cnt;
    n = 0; c_cnt = 0;
    b3_last = 12'h120; b3_up = 1'b1; b3_en = 1'b1;
    for (int k = 0; k < 121; k++) begin
      #1;
      checks++;
      if (b3_c !== (n == 120)) begin
        failures++; $display("FAIL bcd3_seq_c n=%0d got=%b want=%b", n, b3_c, n == 120);
      end
      if (b3_c) c_cnt++;
      tick();
      n = (n == 120) ? 0 : n + 1;
      checks++;
      if (b3_q !== to_bcd3(n)) begin
        failures++; $display("FAIL bcd3_seq_q got=%h want=%h", b3_q, to_bcd3(n));
      end
    end
    checks++;
    if (c_cnt !== 1) begin failures++; $display("FAIL bcd3_c_count got=%0d want=1", c_cnt); end
    b3_en = 1'b0;
  endtask

  task automatic test_down();
    b2_last = 8'h59; b2_up = 1'b0; b2_en = 1'b1;
    #1;
`ifdef CNT_UPDOWN_EN
    checks++;
    if (b2_c !== 1'b1) begin failures++; $display("FAIL down_wrap_c got=%b want=1", b2_c); end
    tick();
    checks++;
    if (b2_q !== 8'h59) begin failures++; $display("FAIL down_wrap_q got=%h want=59", b2_q); end
    #1;
    checks++;
    if (b2_c !== 1'b0) begin failures++; $display("FAIL down_59_c got=%b want=0", b2_c); end
    tick();
    checks++;
    if (b2_q !== 8'h58) begin failures++; $display("FAIL down_58_q got=%h want=58", b2_q); end
    b2_ld = 1'b1; b2_d = 8'h50;
    tick();
    b2_ld = 1'b0;
    tick();
    checks++;
    if (b2_q !== 8'h49) begin failures++; $display("FAIL down_borrow_q got=%h want=49", b2_q); end
    // illegal BCD digit decrements without borrow
    b2_ld = 1'b1; b2_d = 8'h0A;
    tick();
    b2_ld = 1'b0;
    #1;
    checks++;
    if (b2_c !== 1'b0) begin failures++; $display("FAIL down_illegal_c got=%b want=0", b2_c); end
    tick();
    checks++;
    if (b2_q !== 8'h09) begin failures++; $display("FAIL down_illegal_q got=%h want=09", b2_q); end
`else
    checks++;
    if (b2_c !== 1'b0) begin failures++; $display("FAIL upxonly_c got=%b want=0", b2_c); end
    tick();
    checks++;
    if (b2_q !== 8'h01) begin failures++; $display("FAIL uponly_q got=%h want=01", b2_q); end
`endif
    // illegal BCD digit on increment rolls to 0 and carries
    b2_up = 1'b1; b2_ld = 1'b1; b2_d = 8'h0A;
    tick();
    b2_ld = 1'b0;
    #1;
    checks++;
    if (b2_c !== 1'b0) begin failures++; $display("FAIL up_illegal_c got=%b want=0", b2_c); end
    tick();
    checks++;
    if (b2_q !== 8'h10) begin failures++; $display("FAIL up_illegal_q got=%h want=10", b2_q); end
    b2_en = 1'b0;
  endtask

  task automatic test_load();
    h_last = 8'h78; h_up = 1'b1;
    h_ld = 1'b1; h_en = 1'b1; h_d = 8'h33;
    #1;
    checks++;
    if (h_c !== 1'b0) begin failures++; $display("FAIL load_c got=%b want=0", h_c); end
    tick();
    checks++;
    if (h_q !== 8'h33) begin failures++; $display("FAIL load_q got=%h want=33", h_q); end
    h_mr = 1'b1;
    #1;
    checks++;
    if (h_c !== 1'b0) begin failures++; $display("FAIL mr_ld_c got=%b want=0", h_c); end
    tick();
    checks++;
    if (h_q !== 8'h00) begin failures++; $display("FAIL mr_ld_q got=%h want=00", h_q); end
    h_mr = 1'b0; h_d = 8'h55;
    tick();
    h_ld = 1'b0; h_en = 1'b0;
    tick();
    tick();
    checks++;
    if (h_q !== 8'h55) begin failures++; $display("FAIL hold_q got=%h want=55", h_q); end
    checks++;
    if (h_c !== 1'b0) begin failures++; $display("FAIL hold_c got=%b want=0", h_c); end
  endtask

  task automatic test_last_lowered();
    h_last = 8'h78; h_ld = 1'b1; h_d = 8'h3F;
    tick();
    h_ld = 1'b0; h_en = 1'b1;
    tick();
    checks++;
    if (h_q !== 8'h40) begin failures++; $display("FAIL lower_pre_q got=%h want=40", h_q); end
    h_last = 8'h20;
    #1;
    checks++;
    if (h_c !== 1'b1) begin failures++; $display("FAIL lower_c got=%b want=1", h_c); end
    tick();
    checks++;
    if (h_q !== 8'h00) begin failures++; $display("FAIL lower_q got=%h want=00", h_q); end
    h_en = 1'b0; h_last = 8'h78;
  endtask

  task automatic test_mid_reset();
    h_ld = 1'b1; h_d = 8'h46;
    tick();
    h_ld = 1'b0; h_en = 1'b1;
    tick();
    checks++;
    if (h_q !== 8'h47) begin failures++; $display("FAIL midrst_pre_q got=%h want=47", h_q); end
    h_mr = 1'b1;
    tick();
    checks++;
    if (h_q !== 8'h00) begin failures++; $display("FAIL midrst_q got=%h want=00", h_q); end
    h_mr = 1'b0;
    tick();
    checks++;
    if (h_q !== 8'h01) begin failures++; $display("FAIL midrst_01 got=%h want=01", h_q); end
    tick();
    checks++;
    if (h_q !== 8'h02) begin failures++; $display("FAIL midrst_02 got=%h want=02", h_q); end
  endtask

  task automatic test_last_zero();
    h_last = 8'h00; h_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (h_c !== 1'b1) begin failures++; $display("FAIL last0_c got=%b want=1", h_c); end
      tick();
      checks++;
      if (h_q !== 8'h00) begin failures++; $display("FAIL last0_q got=%h want=00", h_q); end
    end
    h_en = 1'b0;
    #1;
    checks++;
    if (h_c !== 1'b0) begin failures++; $display("FAIL last0_noen_c got=%b want=0", h_c); end
  endtask

  task automatic test_back_to_back();
    h_last = 8'hFF; h_ld = 1'b1; h_d = 8'h0F;
    tick();
    h_ld = 1'b0; h_en = 1'b1;
    tick();
    checks++;
    if (h_q !== 8'h10) begin failures++; $display("FAIL b2b_carry_q got=%h want=10", h_q); end
    h_ld = 1'b1; h_d = 8'hFE;
    tick();
    h_ld = 1'b0;
    #1;
    checks++;
    if (h_c !== 1'b0) begin failures++; $display("FAIL b2b_fe_c got=%b want=0", h_c); end
    tick();
    checks++;
    if (h_q !== 8'hFF) begin failures++; $display("FAIL b2b_ff_q got=%h want=ff", h_q); end
    #1;
    checks++;
    if (h_c !== 1'b1) begin failures++; $display("FAIL b2b_ff_c got=%b want=1", h_c); end
    tick();
    checks++;
    if (h_q !== 8'h00) begin failures++; $display("FAIL b2b_wrap_q got=%h want=00", h_q); end
    h_en = 1'b0;
  endtask

  initial begin
    h_mr = 1'b0; h_en = 1'b0; h_ld = 1'b0; h_up = 1'b1; h_d = '0; h_last = 8'h78;
    b3_mr = 1'b0; b3_en = 1'b0; b3_ld = 1'b0; b3_up = 1'b1; b3_d = '0; b3_last = 12'h120;
    b2_mr = 1'b0; b2_en = 1'b0; b2_ld = 1'b0; b2_up = 1'b1; b2_d = '0; b2_last = 8'h59;
    test_reset();
    test_hex_sequence();
    test_bcd_sequence();
    test_down();
    test_load();
    test_last_lowered();
    test_mid_reset();
    test_last_zero();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
